// File: rtl/alu_issue_stage.sv
// ALU issue stage: a single-entry pipeline register between decode and the ALU.
// It forwards source operands from EX/MEM and MEM/WB, selects the SrcB operand,
// decodes the ALU control code, and counts the cycles it spends stalled.
// Ports:
//   clk, reset                        clock and asynchronous active-high reset
//   in_valid / in_ready               decode-side handshake (in_ready is combinational)
//   in_rs1_data, in_rs2_data, in_imm  operand sources
//   in_rs1, in_rs2, in_rd             register indices
//   in_alu_src, in_alu_op, in_funct3, in_funct7b5  decode controls
//   flush                             drops the held entry and blocks capture
//   exmem_*, memwb_*                  forwarding sources
//   out_valid / out_ready             ALU-side handshake
//   SrcA, SrcB, ALUCC, out_rd, out_store_data, illegal_op  registered payload
//   stall_count                       saturating count of stalled cycles
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned OPCODE_LENGTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_alu_src,
  input  logic [1:0]                in_alu_op,
  input  logic [2:0]                in_funct3,
  input  logic                      in_funct7b5,
  input  logic                      flush,
  input  logic                      exmem_regwrite,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  ALUCC,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic                      illegal_op,
  output logic [15:0]               stall_count
);

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] ALU_BAD = OPCODE_LENGTH'(4'b1111);
  localparam logic [15:0]              STALL_MAX = 16'hFFFF;

  logic                     capture;
  logic [DATA_WIDTH-1:0]    rs1_fwd;
  logic [DATA_WIDTH-1:0]    rs2_fwd;
  logic [OPCODE_LENGTH-1:0] alucc_d;
  logic                     illegal_d;

  // Accept when the slot is empty or draining; flush blocks acceptance outright.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign capture  = in_valid && in_ready;

  // Operand forwarding: EX/MEM is newer than MEM/WB; x0 is never forwarded.
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (exmem_regwrite && (exmem_rd == in_rs1) && (in_rs1 != '0))
      rs1_fwd = exmem_result;
    else if (memwb_regwrite && (memwb_rd == in_rs1) && (in_rs1 != '0))
      rs1_fwd = memwb_result;
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    if (exmem_regwrite && (exmem_rd == in_rs2) && (in_rs2 != '0))
      rs2_fwd = exmem_result;
    else if (memwb_regwrite && (memwb_rd == in_rs2) && (in_rs2 != '0))
      rs2_fwd = memwb_result;
  end

  // ALU control decode; anything not listed is flagged illegal.
  always_comb begin
    alucc_d   = ALU_BAD;
    illegal_d = 1'b1;
    case (in_alu_op)
      2'b00: begin alucc_d = ALU_ADD; illegal_d = 1'b0; end
      2'b01: begin alucc_d = ALU_SUB; illegal_d = 1'b0; end
      2'b10: begin
        case (in_funct3)
          3'b000: begin alucc_d = in_funct7b5 ? ALU_SUB : ALU_ADD; illegal_d = 1'b0; end
          3'b111: begin alucc_d = ALU_AND; illegal_d = 1'b0; end
          3'b110: begin alucc_d = ALU_OR;  illegal_d = 1'b0; end
          default: ;
        endcase
      end
      default: begin
        // I-type: funct7b5 is part of the immediate, so it is ignored here.
        case (in_funct3)
          3'b000: begin alucc_d = ALU_ADD; illegal_d = 1'b0; end
          3'b111: begin alucc_d = ALU_AND; illegal_d = 1'b0; end
          3'b110: begin alucc_d = ALU_OR;  illegal_d = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  // Pipeline register, handshake state and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      SrcA           <= '0;
      SrcB           <= '0;
      ALUCC          <= ALU_ADD;
      out_rd         <= '0;
      out_store_data <= '0;
      illegal_op     <= 1'b0;
      stall_count    <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != STALL_MAX))
        stall_count <= stall_count + 16'd1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid      <= 1'b1;
        SrcA           <= rs1_fwd;
        SrcB           <= in_alu_src ? in_imm : rs2_fwd;
        ALUCC          <= alucc_d;
        out_rd         <= in_rd;
        out_store_data <= rs2_fwd;
        illegal_op     <= illegal_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode, forwarding, stall/hold,
// flush, counter saturation and asynchronous reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_alu_src = 1'b0;
  logic [1:0]  in_alu_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic        flush = 1'b0;
  logic        exmem_regwrite = 1'b0, memwb_regwrite = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [63:0] exmem_result = '0, memwb_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] SrcA, SrcB, out_store_data;
  logic [3:0]  ALUCC;
  logic [4:0]  out_rd;
  logic        illegal_op;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUCC(ALUCC), .out_rd(out_rd),
    .out_store_data(out_store_data), .illegal_op(illegal_op),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction; forwarding sources are left as currently set.
  task automatic offer(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd);
    in_valid = 1'b1; in_alu_op = op; in_funct3 = f3; in_funct7b5 = f7;
    in_alu_src = src; in_rs1_data = a; in_rs2_data = b; in_imm = imm;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd;
  endtask

  // Advance one clock edge and sample at the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_illegal"}, 64'(illegal_op), 64'd0);
    check({tag, "_stall"}, 64'(stall_count), 64'd0);
    check({tag, "_srca"}, SrcA, 64'd0);
    check({tag, "_srcb"}, SrcB, 64'd0);
    check({tag, "_store"}, out_store_data, 64'd0);
    check({tag, "_rd"}, 64'(out_rd), 64'd0);
    check({tag, "_alucc"}, 64'(ALUCC), 64'h2);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check_reset_values("rst0");
    check("rst0_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // R-type ADD
    offer(2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd4);
    step();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_srca", SrcA, 64'd5);
    check("add_srcb", SrcB, 64'd7);
    check("add_alucc", 64'(ALUCC), 64'h2);
    check("add_rd", 64'(out_rd), 64'd4);
    check("add_illegal", 64'(illegal_op), 64'd0);
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone, then x0
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 64'd100;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 64'd200;
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd11, 64'd12, 64'd0, 5'd3, 5'd3, 5'd5);
    step();
    check("fwd_exmem_a", SrcA, 64'd100);
    check("fwd_exmem_b", SrcB, 64'd100);
    exmem_regwrite = 1'b0;
    step();
    check("fwd_memwb_a", SrcA, 64'd200);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd55, 64'd66, 64'd0, 5'd0, 5'd0, 5'd5);
    step();
    check("fwd_x0_a", SrcA, 64'd55);
    check("fwd_x0_b", SrcB, 64'd66);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

    // Decode table, back to back
    offer(2'b01, 3'b101, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("beq_sub", 64'(ALUCC), 64'h6);
    offer(2'b10, 3'b000, 1'b1, 1'b0, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("rsub", 64'(ALUCC), 64'h6);
    offer(2'b11, 3'b111, 1'b0, 1'b1, 64'd1, 64'd2, 64'd3, 5'd1, 5'd2, 5'd3);
    step();
    check("andi", 64'(ALUCC), 64'h0);
    offer(2'b10, 3'b110, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("or", 64'(ALUCC), 64'h1);
    offer(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("bad_alucc", 64'(ALUCC), 64'hF);
    check("bad_flag", 64'(illegal_op), 64'd1);
    offer(2'b11, 3'b000, 1'b1, 1'b1, 64'd8, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd3);
    step();
    check("addi_alucc", 64'(ALUCC), 64'h2);
    check("addi_srcb", SrcB, 64'hFFFF_FFFF_FFFF_FFFC);
    check("addi_store", out_store_data, 64'd9);
    check("addi_illegal", 64'(illegal_op), 64'd0);
    in_valid = 1'b0;
    step();

    // Stall and hold for 4 edges, then release into the next instruction
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd11, 64'd1, 64'd0, 5'd1, 5'd2, 5'd7);
    step();
    out_ready = 1'b0;
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd22, 64'd2, 64'd0, 5'd1, 5'd2, 5'd8);
    #1 check("stall_in_ready", 64'(in_ready), 64'd0);
    repeat (4) step();
    check("stall_srca", SrcA, 64'd11);
    check("stall_rd", 64'(out_rd), 64'd7);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_count4", 64'(stall_count), 64'd4);
    out_ready = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);
    step();
    check("release_srca", SrcA, 64'd22);
    check("release_count", 64'(stall_count), 64'd4);

    // Flush wins over a pending capture
    flush = 1'b1;
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd33, 64'd3, 64'd0, 5'd1, 5'd2, 5'd9);
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_srca", SrcA, 64'd22);
    flush = 1'b0; in_valid = 1'b0;

    // Long stall up to saturation on an illegal instruction
    offer(2'b10, 3'b011, 1'b0, 1'b0, 64'd44, 64'd4, 64'd0, 5'd1, 5'd2, 5'd10);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (65530) step();
    check("sat_fffe", 64'(stall_count), 64'hFFFE);
    repeat (3) step();
    check("sat_ffff", 64'(stall_count), 64'hFFFF);
    check("sat_illegal", 64'(illegal_op), 64'd1);

    // Reset mid-stall takes effect before the next edge
    reset = 1'b1;
    #1 check_reset_values("rst1");
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    offer(2'b00, 3'b000, 1'b0, 1'b0, 64'd77, 64'd5, 64'd0, 5'd1, 5'd2, 5'd11);
    step();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_srca", SrcA, 64'd77);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
